// File: rtl/prog_loader.sv
// prog_loader: receives a length-prefixed, little-endian byte stream, packs the
// payload into 32-bit words and writes them to consecutive imem word addresses.
// Once the load finishes it releases the core from reset.
// Stream format: N[7:0], N[15:8], then 4*N payload bytes.
// Build option PROG_LOADER_CHECKSUM_EN: one extra byte follows the payload.
// That byte must equal the XOR of every header and payload byte before it.
module prog_loader #(
    parameter int ADDR_WIDTH = 10
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  in_valid,
    input  logic [7:0]            in_data,
    output logic                  in_ready,
    output logic                  imem_we,
    output logic [ADDR_WIDTH-1:0] imem_addr,
    output logic [31:0]           imem_wdata,
    output logic                  core_rst,
    output logic                  busy,
    output logic                  done,
    output logic                  err,
    output logic [ADDR_WIDTH:0]   words_loaded
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_HDR,
        S_LOAD,
`ifdef PROG_LOADER_CHECKSUM_EN
        S_CHK,
`endif
        S_DONE,
        S_ERR
    } state_t;

`ifdef PROG_LOADER_CHECKSUM_EN
    localparam state_t S_END = S_CHK;
`else
    localparam state_t S_END = S_DONE;
`endif

    // Largest legal word count: the whole imem.
    localparam logic [31:0] CAP = 32'd1 << ADDR_WIDTH;

    state_t      state, nxt;
    logic [1:0]  byte_cnt;
    logic [15:0] len;
    logic [23:0] shreg;
    logic        acc;
    logic        sess_start;
    logic        last_word;
    logic [15:0] hdr_n;
`ifdef PROG_LOADER_CHECKSUM_EN
    logic [7:0]  csum;
`endif

    // Next-state decode and state-derived outputs.
    always_comb begin
        nxt        = state;
        in_ready   = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;
        err        = 1'b0;
        core_rst   = 1'b0;
        sess_start = 1'b0;
        hdr_n      = {in_data, len[7:0]};
        // The word completing with this byte is the final one of the program.
        last_word  = (32'(words_loaded) + 32'd1) == 32'(len);
        case (state)
            S_IDLE: begin
                if (start) begin
                    nxt        = S_HDR;
                    sess_start = 1'b1;
                end
            end
            S_HDR: begin
                in_ready = 1'b1;
                busy     = 1'b1;
                if (in_valid && byte_cnt[0]) begin
                    if (hdr_n == 16'd0)
                        nxt = S_END;
                    else if (32'(hdr_n) > CAP)
                        nxt = S_ERR;
                    else
                        nxt = S_LOAD;
                end
            end
            S_LOAD: begin
                in_ready = 1'b1;
                busy     = 1'b1;
                if (in_valid && byte_cnt == 2'd3 && last_word)
                    nxt = S_END;
            end
`ifdef PROG_LOADER_CHECKSUM_EN
            S_CHK: begin
                in_ready = 1'b1;
                busy     = 1'b1;
                if (in_valid)
                    nxt = (in_data == csum) ? S_DONE : S_ERR;
            end
`endif
            S_DONE: begin
                done     = 1'b1;
                core_rst = 1'b1;
                if (start) begin
                    nxt        = S_HDR;
                    sess_start = 1'b1;
                end
            end
            S_ERR: begin
                err = 1'b1;
                if (start) begin
                    nxt        = S_HDR;
                    sess_start = 1'b1;
                end
            end
            default: nxt = S_IDLE;
        endcase
        acc = in_valid & in_ready;
    end

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            state <= S_IDLE;
        else
            state <= nxt;
    end

    // Header capture, word packing and the one-cycle imem write strobe.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            byte_cnt     <= 2'd0;
            len          <= 16'd0;
            shreg        <= 24'd0;
            imem_we      <= 1'b0;
            imem_addr    <= '0;
            imem_wdata   <= 32'd0;
            words_loaded <= '0;
        end else begin
            imem_we <= 1'b0;
            if (sess_start) begin
                byte_cnt     <= 2'd0;
                words_loaded <= '0;
            end else if (acc && state == S_HDR) begin
                if (!byte_cnt[0]) begin
                    len[7:0] <= in_data;
                    byte_cnt <= 2'd1;
                end else begin
                    len[15:8] <= in_data;
                    byte_cnt  <= 2'd0;
                end
            end else if (acc && state == S_LOAD) begin
                byte_cnt <= byte_cnt + 2'd1;
                if (byte_cnt == 2'd3) begin
                    imem_we      <= 1'b1;
                    imem_addr    <= words_loaded[ADDR_WIDTH-1:0];
                    imem_wdata   <= {in_data, shreg};
                    words_loaded <= words_loaded + {{ADDR_WIDTH{1'b0}}, 1'b1};
                end else begin
                    // Earlier bytes shift down so b0 ends up in the low byte.
                    shreg <= {in_data, shreg[23:8]};
                end
            end
        end
    end

`ifdef PROG_LOADER_CHECKSUM_EN
    // Running XOR over header and payload bytes.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            csum <= 8'd0;
        else if (sess_start)
            csum <= 8'd0;
        else if (acc && (state == S_HDR || state == S_LOAD))
            csum <= csum ^ in_data;
    end
`endif

endmodule

// File: tb/tb_prog_loader.sv
// Randomized bench for prog_loader against a stream-level reference model.
// Works in both builds; the PROG_LOADER_CHECKSUM_EN macro switches the model.
`timescale 1ns/1ps
module tb_prog_loader;
    localparam int AW  = 10;
    localparam int CAP = 1 << AW;
`ifdef PROG_LOADER_CHECKSUM_EN
    localparam bit CHK_EN = 1'b1;
`else
    localparam bit CHK_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          start = 1'b0;
    logic          in_valid = 1'b0;
    logic [7:0]    in_data = 8'd0;
    logic          in_ready;
    logic          imem_we;
    logic [AW-1:0] imem_addr;
    logic [31:0]   imem_wdata;
    logic          core_rst;
    logic          busy;
    logic          done;
    logic          err;
    logic [AW:0]   words_loaded;

    int n_chk  = 0;
    int n_fail = 0;

    logic [AW-1:0] got_a[$];
    logic [31:0]   got_d[$];
    logic [AW:0]   got_wl[$];
    logic [7:0]    stim[$];

    always #5 clk = ~clk;

    prog_loader #(.ADDR_WIDTH(AW)) dut (
        .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready), .imem_we(imem_we), .imem_addr(imem_addr),
        .imem_wdata(imem_wdata), .core_rst(core_rst), .busy(busy), .done(done),
        .err(err), .words_loaded(words_loaded)
    );

    // Record every imem write away from the active edge.
    always @(negedge clk) begin
        if (rst && imem_we) begin
            got_a.push_back(imem_addr);
            got_d.push_back(imem_wdata);
            got_wl.push_back(words_loaded);
        end
    end

    initial begin
        #500us;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic check_zero(input string tag);
        check($sformatf("%s:flags", tag), {in_ready, imem_we, core_rst, busy, done, err}, 64'd0);
        check($sformatf("%s:addr", tag), imem_addr, 64'd0);
        check($sformatf("%s:wdata", tag), imem_wdata, 64'd0);
        check($sformatf("%s:words", tag), words_loaded, 64'd0);
    endtask

    task automatic pulse_start;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
    endtask

    // Present one byte after a random gap; optionally throw start pulses at a busy loader.
    task automatic send_byte(input logic [7:0] b, input int maxgap, input bit spam);
        int gap;
        int waited;
        gap = (maxgap > 0) ? int'($urandom_range(0, maxgap)) : 0;
        repeat (gap) begin
            @(negedge clk);
            in_valid = 1'b0;
            in_data  = 8'($urandom);
            start    = spam & in_ready & 1'($urandom);
        end
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = b;
        start    = spam & in_ready & 1'($urandom);
        waited   = 0;
        while (!in_ready && waited < 100) begin
            @(negedge clk);
            start = 1'b0;
            waited++;
        end
        if (!in_ready) begin
            check("ready_timeout", 64'd0, 64'd1);
            in_valid = 1'b0;
            return;
        end
        @(posedge clk);
    endtask

    // Build a program of n random words; the checksum byte is appended in the checksum build.
    task automatic make_prog(input int n, input bit bad_chk);
        logic [7:0] x;
        stim.delete();
        stim.push_back(8'(n));
        stim.push_back(8'(n >> 8));
        for (int i = 0; i < 4 * n; i++) stim.push_back(8'($urandom));
        if (CHK_EN) begin
            x = 8'd0;
            foreach (stim[i]) x ^= stim[i];
            stim.push_back(bad_chk ? (x ^ 8'($urandom_range(1, 255))) : x);
        end
    endtask

    // Drive stim[] and compare against the stream-level model of the expected result.
    task automatic run_session(input string tag, input int maxgap, input bit spam, input bit do_start);
        int n;
        int nw;
        bit cap_err;
        bit ok;
        logic [7:0]  x;
        logic [31:0] w;
        got_a.delete();
        got_d.delete();
        got_wl.delete();
        if (do_start) pulse_start();
        foreach (stim[i]) send_byte(stim[i], maxgap, spam);
        @(negedge clk);
        in_valid = 1'b0;
        start    = 1'b0;
        repeat (3) @(negedge clk);

        n       = {stim[1], stim[0]};
        cap_err = (n > CAP);
        nw      = cap_err ? 0 : n;
        ok      = !cap_err;
        if (!cap_err && CHK_EN) begin
            x = 8'd0;
            for (int i = 0; i < 2 + 4 * n; i++) x ^= stim[i];
            ok = (stim.size() > 2 + 4 * n) && (stim[2 + 4 * n] == x);
        end

        check($sformatf("%s:nwrites", tag), got_a.size(), nw);
        for (int i = 0; i < nw && i < got_a.size(); i++) begin
            w = {stim[2+4*i+3], stim[2+4*i+2], stim[2+4*i+1], stim[2+4*i]};
            check($sformatf("%s:addr%0d", tag, i), got_a[i], i);
            check($sformatf("%s:data%0d", tag, i), got_d[i], w);
            check($sformatf("%s:wl%0d", tag, i), got_wl[i], i + 1);
        end
        check($sformatf("%s:words", tag), words_loaded, nw);
        check($sformatf("%s:done", tag), done, ok);
        check($sformatf("%s:err", tag), err, !ok);
        check($sformatf("%s:core_rst", tag), core_rst, ok);
        check($sformatf("%s:busy", tag), busy, 64'd0);
        check($sformatf("%s:in_ready", tag), in_ready, 64'd0);
        if (nw > 0) begin
            w = {stim[2+4*(nw-1)+3], stim[2+4*(nw-1)+2], stim[2+4*(nw-1)+1], stim[2+4*(nw-1)]};
            check($sformatf("%s:hold_addr", tag), imem_addr, nw - 1);
            check($sformatf("%s:hold_data", tag), imem_wdata, w);
        end
    endtask

    task automatic load_example(input logic [7:0] chk);
        stim = '{8'h02, 8'h00, 8'h93, 8'h02, 8'h50, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00};
        if (CHK_EN) stim.push_back(chk);
    endtask

    initial begin
        // Reset state and idle behaviour.
        repeat (3) @(negedge clk);
        check_zero("reset");
        rst = 1'b1;
        in_valid = 1'b1;
        in_data  = 8'h5A;
        repeat (3) @(negedge clk);
        check_zero("idle_no_start");
        check("idle_nwrites", got_a.size(), 64'd0);
        in_valid = 1'b0;

        // Async reset in the middle of a load.
        pulse_start();
        foreach (stim[i]) stim.delete(i);
        send_byte(8'h02, 0, 0);
        send_byte(8'h00, 0, 0);
        send_byte(8'h93, 0, 0);
        send_byte(8'h02, 0, 0);
        send_byte(8'h50, 0, 0);
        send_byte(8'h00, 0, 0);
        send_byte(8'h13, 0, 0);
        @(negedge clk);
        #2 rst = 1'b0;
        #1 check_zero("rst_midload");
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        check("after_rst_busy", busy, 64'd0);
        in_valid = 1'b0;

        // Example program: addi x5,x0,5 ; addi x0,x0,0.
        load_example(8'hD0);
        run_session("example", 0, 0, 1);
        check("example_w0", (got_d.size() > 0) ? got_d[0] : 32'hDEAD_BEEF, 64'h00500293);
        check("example_w1", (got_d.size() > 1) ? got_d[1] : 32'hDEAD_BEEF, 64'h00000013);

        // Restart from DONE: core goes back into reset on the next edge.
        pulse_start();
        check("restart_core_rst", core_rst, 64'd0);
        check("restart_done", done, 64'd0);
        check("restart_busy", busy, 64'd1);

        // Empty program.
        stim = '{8'h00, 8'h00};
        if (CHK_EN) stim.push_back(8'h00);
        run_session("empty", 0, 0, 0);

        // Over-capacity header 1025 words.
        stim = '{8'h01, 8'h04};
        run_session("overcap", 0, 0, 1);
        pulse_start();
        check("err_restart_busy", busy, 64'd1);
        check("err_restart_err", err, 64'd0);
        make_prog(3, 1'b0);
        run_session("after_err", 0, 0, 0);

        // Checksum build: wrong checksum byte.
        if (CHK_EN) begin
            load_example(8'hD1);
            run_session("bad_chk", 0, 0, 1);
        end

        // Example program again with random gaps and start pulses while busy.
        load_example(8'hD0);
        run_session("example_gaps", 3, 1, 1);

        // Random programs.
        for (int t = 0; t < 10; t++) begin
            make_prog($urandom_range(1, 6), CHK_EN & 1'($urandom));
            run_session($sformatf("rand%0d", t), 3, 1, 1);
        end

        // Random oversize header.
        stim.delete();
        begin
            int big;
            big = $urandom_range(CAP + 1, 65535);
            stim.push_back(8'(big));
            stim.push_back(8'(big >> 8));
        end
        run_session("rand_overcap", 2, 1, 1);

        // Exactly full memory.
        make_prog(CAP, 1'b0);
        run_session("full", 0, 0, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
